// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the femtoRV32 fetch stage: widths, reset PC,
// the NOP used to seed the decode buffer, and the fetch state encoding.
package fetch_pc_unit_pkg;

    localparam int          FETCH_XLEN     = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage of the femtoRV32 core.
// Issues one instruction-memory request at a time, buffers the returned
// word for decode, and refetches from the target on a taken redirect.
// Optional macro FETCH_MISALIGN_TRAP_EN: a redirect to a target that is not
// word aligned is refused and reported on misalign_fault/fault_addr instead
// of being silently aligned.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            should_jump,
    input  logic [XLEN-1:0] jump_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_fault,
    output logic [XLEN-1:0] fault_addr
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            req_valid_q, req_valid_d;
    logic            if_valid_q, if_valid_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            req_accept;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic            target_misaligned;

    // A misaligned target is refused: the PC keeps running and the bad address is latched for the trap handler.
    always_comb begin
        target_misaligned = (jump_target[1:0] != 2'b00);
        redirect          = should_jump && !target_misaligned;
        redirect_pc       = jump_target;
        fault_d           = should_jump && target_misaligned;
        fault_addr_d      = fault_d ? jump_target : fault_addr_q;
    end

    // Fault pulse and captured address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign misalign_fault = fault_q;
    assign fault_addr     = fault_addr_q;
`else
    // Without the trap, every redirect is taken and forced onto a word boundary.
    always_comb begin
        redirect    = should_jump;
        redirect_pc = jump_target & ~XLEN'(3);
    end
`endif

    assign req_accept = req_valid_q && imem_req_ready;

    // Next-state logic: redirect wins over handshakes, and a request already accepted when the redirect hits leaves a stale response to drop.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        case (state_q)
            FS_REQ: begin
                if (req_accept) begin
                    state_d = FS_WAIT;
                end
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (req_accept) begin
                        drop_d = 1'b1;
                    end
                end
            end
            FS_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop_q || redirect) begin
                        drop_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        if_instr_d = imem_resp_data;
                        if_pc_d    = pc_q;
                        state_d    = FS_HOLD;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
                if (redirect) begin
                    pc_d = redirect_pc;
                end
            end
            FS_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FS_REQ;
                end else if (if_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = FS_REQ;
                end
            end
            default: begin
                state_d = FS_REQ;
            end
        endcase
        req_valid_d = (state_d == FS_REQ);
        if_valid_d  = (state_d == FS_HOLD);
    end

    // Fetch state, PC and decode buffer registers; handshake valids are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FS_REQ;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            if_instr_q  <= NOP_INSTR;
            if_pc_q     <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            req_valid_q <= req_valid_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    assign if_pc_plus4    = if_pc_q + XLEN'(4);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit. A cycle-stepped memory responder
// and an instruction-stream model (sequential PCs restarting at each
// redirect target) check every instruction handed to decode.
// Honours FETCH_MISALIGN_TRAP_EN when defined.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        should_jump;
    logic [31:0] jump_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_fault;
    logic [31:0] fault_addr;
`endif

    fetch_pc_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .should_jump     (should_jump),
        .jump_target     (jump_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault  (misalign_fault),
        .fault_addr      (fault_addr)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests  = 0;
    int failed = 0;

    bit          jumpIn;
    logic [31:0] tgtIn;
    bit          reqReadyIn;
    bit          ifReadyIn;
    int          latency;

    bit          memPending;
    logic [31:0] memAddr;
    int          memCount;
    bit          respNow;

    logic [31:0] expPc;
    int          acceptCount;
    int          deliverCount;
    logic [31:0] lastAcceptAddr;
    logic [31:0] lastDeliveredPc;
    logic [31:0] acceptQ[$];
    int          cycleNum;
    int          firstAcceptCycle;
    int          firstValidCycle;

    bit          prevIfHold;
    bit          prevReqHold;
    logic [31:0] prevIfPc;
    logic [31:0] prevIfInstr;
    logic [31:0] prevReqAddr;
    bit          expFault;
    logic [31:0] expFaultAddr;

    bit          sReqValid;
    bit          sIfValid;
    logic [31:0] sIfPc;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_00F3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        if (memPending) memCount--;
        respNow         = memPending && (memCount == 0);
        should_jump     = jumpIn;
        jump_target     = tgtIn;
        imem_req_ready  = reqReadyIn;
        if_ready        = ifReadyIn;
        imem_resp_valid = respNow;
        imem_resp_data  = respNow ? memWord(memAddr) : $urandom();
        #1;
        sReqValid = imem_req_valid;
        sIfValid  = if_valid;
        sIfPc     = if_pc;
        if (prevIfHold) begin
            checkOutput("hold_valid", 32'(if_valid), 32'd1);
            checkOutput("hold_pc", if_pc, prevIfPc);
            checkOutput("hold_instr", if_instr, prevIfInstr);
        end
        if (prevReqHold) begin
            checkOutput("req_hold_valid", 32'(imem_req_valid), 32'd1);
            checkOutput("req_hold_addr", imem_req_addr, prevReqAddr);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("fault_pulse", 32'(misalign_fault), 32'(expFault));
        if (expFault) checkOutput("fault_addr", fault_addr, expFaultAddr);
        expFault = 1'b0;
`endif
        if (respNow) memPending = 1'b0;
        if (imem_req_valid && imem_req_ready) begin
            checkOutput("one_outstanding", 32'(memPending), 32'd0);
            memPending     = 1'b1;
            memAddr        = imem_req_addr;
            memCount       = latency;
            acceptCount++;
            lastAcceptAddr = imem_req_addr;
            acceptQ.push_back(imem_req_addr);
            if (firstAcceptCycle < 0) firstAcceptCycle = cycleNum;
        end
        if (if_valid && firstValidCycle < 0) firstValidCycle = cycleNum;
        if (if_valid && if_ready) begin
            checkOutput("deliver_pc", if_pc, expPc);
            checkOutput("deliver_instr", if_instr, memWord(expPc));
            checkOutput("deliver_pc_plus4", if_pc_plus4, expPc + 32'd4);
            lastDeliveredPc = if_pc;
            deliverCount++;
            expPc = expPc + 32'd4;
        end
        if (jumpIn) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgtIn[1:0] != 2'b00) begin
                expFault     = 1'b1;
                expFaultAddr = tgtIn;
            end else begin
                expPc = tgtIn;
            end
`else
            expPc = {tgtIn[31:2], 2'b00};
`endif
        end
        prevIfHold  = if_valid && !if_ready && !jumpIn;
        prevIfPc    = if_pc;
        prevIfInstr = if_instr;
        prevReqHold = imem_req_valid && !imem_req_ready && !jumpIn;
        prevReqAddr = imem_req_addr;
        jumpIn      = 1'b0;
        cycleNum++;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n           = 1'b0;
        should_jump     = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        if_ready        = 1'b0;
        memPending      = 1'b0;
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_req_addr", imem_req_addr, 32'h0);
        checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_if_instr", if_instr, 32'h0000_0013);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_pc_plus4", if_pc_plus4, 32'h4);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("rst_fault", 32'(misalign_fault), 32'd0);
`endif
        expPc            = 32'h0;
        prevIfHold       = 1'b0;
        prevReqHold      = 1'b0;
        expFault         = 1'b0;
        firstAcceptCycle = -1;
        firstValidCycle  = -1;
        acceptQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runUntilDeliver(input int target, input int maxCycles);
        for (int i = 0; i < maxCycles && deliverCount < target; i++) applyStimulus();
        checkOutput("deliver_timeout", 32'(deliverCount >= target), 32'd1);
    endtask

    task automatic runUntilAccept(input int target, input int maxCycles);
        for (int i = 0; i < maxCycles && acceptCount < target; i++) applyStimulus();
        checkOutput("accept_timeout", 32'(acceptCount >= target), 32'd1);
    endtask

    // Directed scenarios, a randomized phase, then a mid-run reset.
    initial begin
        int          mark;
        int          markQ;
        int          startDeliver;
        logic [31:0] expNext;

        rst_n = 1'b0; should_jump = 1'b0; jump_target = '0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; if_ready = 1'b0;
        jumpIn = 1'b0; tgtIn = '0; reqReadyIn = 1'b1; ifReadyIn = 1'b1; latency = 1;
        memPending = 1'b0; memCount = 0; cycleNum = 0; acceptCount = 0; deliverCount = 0;
        doReset();

        runUntilDeliver(2, 20);
        checkOutput("t1_req0", acceptQ.size() > 0 ? acceptQ[0] : 32'hDEAD_BEEF, 32'h0);
        checkOutput("t1_req1", acceptQ.size() > 1 ? acceptQ[1] : 32'hDEAD_BEEF, 32'h4);
        checkOutput("t1_first_latency", 32'(firstValidCycle - firstAcceptCycle), 32'd2);

        ifReadyIn = 1'b0;
        for (int i = 0; i < 20 && !(sIfValid && sIfPc == 32'h8); i++) applyStimulus();
        checkOutput("t2_hold_pc", sIfPc, 32'h8);
        checkOutput("t2_req2", acceptQ.size() > 2 ? acceptQ[2] : 32'hDEAD_BEEF, 32'h8);
        repeat (5) begin
            applyStimulus();
            checkOutput("t2_no_req", 32'(sReqValid), 32'd0);
        end
        ifReadyIn = 1'b1;
        runUntilAccept(acceptCount + 1, 10);
        checkOutput("t2_next_req", lastAcceptAddr, 32'hC);

        latency = 3;
        runUntilAccept(acceptCount + 1, 10);
        mark = acceptCount; markQ = acceptQ.size();
        jumpIn = 1'b1; tgtIn = 32'h100;
        applyStimulus();
        checkOutput("t3_no_resp_yet", 32'(respNow), 32'd0);
        runUntilDeliver(deliverCount + 1, 30);
        checkOutput("t3_pc", lastDeliveredPc, 32'h100);
        checkOutput("t3_req_count", 32'(acceptCount - mark), 32'd1);
        checkOutput("t3_req_addr", acceptQ.size() > markQ ? acceptQ[markQ] : 32'hDEAD_BEEF, 32'h100);

        latency = 1;
        runUntilAccept(acceptCount + 1, 10);
        mark = acceptCount; markQ = acceptQ.size();
        jumpIn = 1'b1; tgtIn = 32'h200;
        applyStimulus();
        checkOutput("t4_resp_same_cycle", 32'(respNow), 32'd1);
        runUntilDeliver(deliverCount + 1, 20);
        checkOutput("t4_pc", lastDeliveredPc, 32'h200);
        checkOutput("t4_req_count", 32'(acceptCount - mark), 32'd1);
        checkOutput("t4_req_addr", acceptQ.size() > markQ ? acceptQ[markQ] : 32'hDEAD_BEEF, 32'h200);

        mark = acceptCount; markQ = acceptQ.size();
        jumpIn = 1'b1; tgtIn = 32'h300;
        applyStimulus();
        checkOutput("t5_accept_with_jump", 32'(acceptCount - mark), 32'd1);
        runUntilDeliver(deliverCount + 1, 20);
        checkOutput("t5_pc", lastDeliveredPc, 32'h300);
        checkOutput("t5_req_count", 32'(acceptCount - mark), 32'd2);
        checkOutput("t5_req_addr", acceptQ.size() > markQ + 1 ? acceptQ[markQ + 1] : 32'hDEAD_BEEF, 32'h300);

        jumpIn = 1'b1; tgtIn = 32'hFFFF_FFFC;
        applyStimulus();
        runUntilDeliver(deliverCount + 1, 20);
        checkOutput("t6_top_pc", lastDeliveredPc, 32'hFFFF_FFFC);
        runUntilDeliver(deliverCount + 1, 20);
        checkOutput("t6_wrap_pc", lastDeliveredPc, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
        expNext = expPc;
`else
        expNext = 32'h100;
`endif
        jumpIn = 1'b1; tgtIn = 32'h102;
        applyStimulus();
        runUntilDeliver(deliverCount + 1, 20);
        checkOutput("t7_misalign_pc", lastDeliveredPc, expNext);

        startDeliver = deliverCount;
        for (int i = 0; i < 400; i++) begin
            reqReadyIn = ($urandom_range(0, 3) != 0);
            ifReadyIn  = ($urandom_range(0, 2) != 0);
            latency    = int'($urandom_range(1, 3));
            jumpIn     = ($urandom_range(0, 15) == 0);
            tgtIn      = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom_range(0, 63) << 2);
            applyStimulus();
        end
        checkOutput("rand_progress", 32'(deliverCount > startDeliver + 20), 32'd1);

        reqReadyIn = 1'b1; ifReadyIn = 1'b1; latency = 1;
        repeat (3) applyStimulus();
        doReset();
        runUntilDeliver(deliverCount + 1, 20);
        checkOutput("reset_restart_pc", lastDeliveredPc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
